// File: rtl/ex_wb_writeback.sv
// ex_wb_writeback: EX/WB pipeline register, 8x8 register file writeback and retire counter
// Optional same-cycle read bypass of the committing result under WB_WRITETHROUGH_EN.
module ex_wb_writeback #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int RETIRE_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic [DATA_W-1:0]     ex_result,
  output logic [REG_ADDR_W-1:0] rd_ex_wb,
  output logic                  regwrite_ex_wb,
  output logic [DATA_W-1:0]     result_ex_wb,
  output logic                  valid_ex_wb,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0]     rs1_data,
  output logic [DATA_W-1:0]     rs2_data,
  output logic [RETIRE_W-1:0]   retire_count
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic commit;
  logic wr_en;
  // flush only replaces the incoming instruction; the one already in WB still retires
  assign commit = valid_ex_wb & ~stall_i;
  assign wr_en  = commit & regwrite_ex_wb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex_wb    <= 1'b0;
      regwrite_ex_wb <= 1'b0;
      rd_ex_wb       <= '0;
      result_ex_wb   <= '0;
    end else if (flush_i) begin
      valid_ex_wb    <= 1'b0;
      regwrite_ex_wb <= 1'b0;
      rd_ex_wb       <= '0;
      result_ex_wb   <= '0;
    end else if (!stall_i) begin
      valid_ex_wb    <= ex_valid;
      regwrite_ex_wb <= ex_valid & ex_regwrite;
      rd_ex_wb       <= ex_rd;
      result_ex_wb   <= ex_result;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd_ex_wb] <= result_ex_wb;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_count <= '0;
    else if (commit) retire_count <= retire_count + 1'b1;
  end
`ifdef WB_WRITETHROUGH_EN
  assign rs1_data = (wr_en && rs1_addr == rd_ex_wb) ? result_ex_wb : rf[rs1_addr];
  assign rs2_data = (wr_en && rs2_addr == rd_ex_wb) ? result_ex_wb : rf[rs2_addr];
`else
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
`endif
endmodule

// File: tb/tb_ex_wb_writeback.sv
// tb_ex_wb_writeback: directed vector table plus stall/flush/bypass/reset/wrap sequences
module tb_ex_wb_writeback;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_i, flush_i, ex_valid, ex_regwrite;
  logic [2:0] ex_rd, rd_ex_wb, rs1_addr, rs2_addr;
  logic [7:0] ex_result, result_ex_wb, rs1_data, rs2_data;
  logic       regwrite_ex_wb, valid_ex_wb;
  logic [15:0] retire_count;
  int n_cmp = 0;
  int n_err = 0;

  ex_wb_writeback dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_result(ex_result),
    .rd_ex_wb(rd_ex_wb), .regwrite_ex_wb(regwrite_ex_wb), .result_ex_wb(result_ex_wb),
    .valid_ex_wb(valid_ex_wb), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       rw;
    logic [2:0] rd;
    logic [7:0] res;
    logic       e_valid;
    logic       e_rw;
    logic [2:0] e_rd;
    logic [7:0] e_res;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [2:0] rd, input logic [7:0] res);
    ex_valid = v; ex_regwrite = rw; ex_rd = rd; ex_result = res;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a1, input logic [7:0] e1,
                        input logic [2:0] a2, input logic [7:0] e2);
    rs1_addr = a1; rs2_addr = a2;
    #1;
    chk({name, "_rs1"}, 32'(rs1_data), 32'(e1));
    chk({name, "_rs2"}, 32'(rs2_data), 32'(e2));
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 3'd1, 8'h10, 1'b1, 1'b1, 3'd1, 8'h10, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 3'd2, 8'h22, 1'b1, 1'b0, 3'd2, 8'h22, 16'd1};
    tbl[2] = '{1'b0, 1'b1, 3'd3, 8'h33, 1'b0, 1'b0, 3'd3, 8'h33, 16'd2};
    tbl[3] = '{1'b1, 1'b1, 3'd0, 8'h44, 1'b1, 1'b1, 3'd0, 8'h44, 16'd2};
    tbl[4] = '{1'b1, 1'b1, 3'd7, 8'hF0, 1'b1, 1'b1, 3'd7, 8'hF0, 16'd3};

    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    #3;
    chk("rst_valid", 32'(valid_ex_wb), 0);
    chk("rst_rw", 32'(regwrite_ex_wb), 0);
    chk("rst_rd", 32'(rd_ex_wb), 0);
    chk("rst_res", 32'(result_ex_wb), 0);
    chk("rst_cnt", 32'(retire_count), 0);
    rd_chk("rst_rf", 3'd3, 8'h00, 3'd7, 8'h00);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].valid, tbl[i].rw, tbl[i].rd, tbl[i].res);
      step();
      chk($sformatf("v%0d_valid", i), 32'(valid_ex_wb), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_rw", i), 32'(regwrite_ex_wb), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d_rd", i), 32'(rd_ex_wb), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_res", i), 32'(result_ex_wb), 32'(tbl[i].e_res));
      chk($sformatf("v%0d_cnt", i), 32'(retire_count), 32'(tbl[i].e_cnt));
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("tbl_drain_cnt", 32'(retire_count), 4);
    rd_chk("tbl_r0r7", 3'd0, 8'h44, 3'd7, 8'hF0);
    rd_chk("tbl_r1r2", 3'd1, 8'h10, 3'd2, 8'h00);
    rd_chk("tbl_r3", 3'd3, 8'h00, 3'd3, 8'h00);

    drive(1'b1, 1'b1, 3'd3, 8'hA5);
    step();
    chk("a5_rd", 32'(rd_ex_wb), 3);
    chk("a5_rw", 32'(regwrite_ex_wb), 1);
    chk("a5_res", 32'(result_ex_wb), 32'hA5);
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("a5_cnt", 32'(retire_count), 5);
    rd_chk("a5_rf", 3'd3, 8'hA5, 3'd3, 8'hA5);

    drive(1'b1, 1'b1, 3'd5, 8'h3C);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_cnt", i), 32'(retire_count), 5);
      rd_chk($sformatf("stall%0d_rf", i), 3'd5, 8'h00, 3'd5, 8'h00);
      chk($sformatf("stall%0d_valid", i), 32'(valid_ex_wb), 1);
    end
    stall_i = 1'b0;
    step();
    chk("unstall_cnt", 32'(retire_count), 6);
    rd_chk("unstall_rf", 3'd5, 8'h3C, 3'd5, 8'h3C);
    step();
    chk("unstall_once_cnt", 32'(retire_count), 6);

    drive(1'b1, 1'b1, 3'd2, 8'h11);
    step();
    drive(1'b1, 1'b1, 3'd6, 8'h66);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    chk("flush_valid", 32'(valid_ex_wb), 0);
    chk("flush_rw", 32'(regwrite_ex_wb), 0);
    chk("flush_res", 32'(result_ex_wb), 0);
    chk("flush_cnt", 32'(retire_count), 7);
    rd_chk("flush_rf", 3'd2, 8'h11, 3'd6, 8'h00);
    step();
    chk("flush_bubble_cnt", 32'(retire_count), 7);
    rd_chk("flush_rf6", 3'd6, 8'h00, 3'd6, 8'h00);

    drive(1'b1, 1'b1, 3'd4, 8'h01);
    step();
    drive(1'b1, 1'b1, 3'd4, 8'h7E);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
`ifdef WB_WRITETHROUGH_EN
    rd_chk("wt_same", 3'd4, 8'h7E, 3'd4, 8'h7E);
`else
    rd_chk("wt_same", 3'd4, 8'h01, 3'd4, 8'h01);
`endif
    step();
    rd_chk("wt_next", 3'd4, 8'h7E, 3'd4, 8'h7E);
    chk("wt_cnt", 32'(retire_count), 9);

    drive(1'b1, 1'b1, 3'd1, 8'h99);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00);
    stall_i = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_ex_wb), 0);
    chk("mrst_rw", 32'(regwrite_ex_wb), 0);
    chk("mrst_rd", 32'(rd_ex_wb), 0);
    chk("mrst_res", 32'(result_ex_wb), 0);
    chk("mrst_cnt", 32'(retire_count), 0);
    rd_chk("mrst_rf", 3'd4, 8'h00, 3'd1, 8'h00);
    #1;
    rst_n = 1'b1;
    stall_i = 1'b0;
    step();
    step();
    chk("mrst_lost_cnt", 32'(retire_count), 0);
    rd_chk("mrst_lost_rf", 3'd1, 8'h00, 3'd5, 8'h00);

    drive(1'b1, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 65536; i++) step();
    chk("wrap_max_cnt", 32'(retire_count), 32'hFFFF);
    step();
    chk("wrap_zero_cnt", 32'(retire_count), 0);
    rd_chk("wrap_nowrite", 3'd0, 8'h00, 3'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
